// File: rtl/bool_tt_pkg.sv
// Shared types and truth-table constants for the boolean function pipe.
package bool_tt_pkg;

    typedef logic [3:0] tt_t;

    // Truth table indexed by {a,b}: bit0=f(0,0) .. bit3=f(1,1)
    localparam tt_t TT_AND   = 4'b1000;
    localparam tt_t TT_OR    = 4'b1110;
    localparam tt_t TT_XOR   = 4'b0110;
    localparam tt_t TT_IMPL  = 4'b1011;
    localparam tt_t TT_NIMPL = 4'b0100;
    localparam tt_t TT_NAND  = 4'b0111;

    typedef enum logic {ST_IDLE, ST_ACC} state_t;

endpackage

// File: rtl/bool_tt_pipe_if.sv
// Valid/ready source and sink bundle plus configuration for bool_tt_pipe.
interface bool_tt_pipe_if #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = 8
);
    logic                   in_valid;
    logic                   in_ready;
    logic [WIDTH-1:0]       in_a;
    logic [WIDTH-1:0]       in_b;
    logic                   in_last;
    bool_tt_pkg::tt_t       cfg_tt;
    logic                   cfg_fold;
    logic                   out_valid;
    logic                   out_ready;
    logic [WIDTH-1:0]       out_data;
    logic [CNT_W-1:0]       out_beats;
    logic                   out_sat;

    modport master (
        output in_valid, in_a, in_b, in_last, cfg_tt, cfg_fold, out_ready,
        input  in_ready, out_valid, out_data, out_beats, out_sat
    );

    modport slave (
        input  in_valid, in_a, in_b, in_last, cfg_tt, cfg_fold, out_ready,
        output in_ready, out_valid, out_data, out_beats, out_sat
    );
endinterface

// File: rtl/bool_tt_lane.sv
// Bitwise truth-table lookup: res[i] = tt[{x[i],y[i]}], purely combinational.
module bool_tt_lane
    import bool_tt_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  tt_t              tt_i,
    input  logic [WIDTH-1:0] x_i,
    input  logic [WIDTH-1:0] y_i,
    output logic [WIDTH-1:0] res_o
);

    always_comb begin
        res_o = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            res_o[i] = tt_i[{x_i[i], y_i[i]}];
        end
    end

endmodule

// File: rtl/bool_tt_pipe.sv
// Registered two-operand truth-table unit: per-beat MAP or packet FOLD (acc = f(acc,a)).
module bool_tt_pipe
    import bool_tt_pkg::*;
#(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned MAX_BEATS = 255
) (
    input  logic           clk,
    input  logic           rst_n,
    bool_tt_pipe_if.slave  bus
);

    localparam int unsigned     CNT_W   = $clog2(MAX_BEATS + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_BEATS);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_t           state_q,     state_d;
    logic [WIDTH-1:0] acc_q,       acc_d;
    logic [CNT_W-1:0] cnt_q,       cnt_d;
    logic             sat_q,       sat_d;
    tt_t              tt_q,        tt_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_data_q,  out_data_d;
    logic [CNT_W-1:0] out_beats_q, out_beats_d;
    logic             out_sat_q,   out_sat_d;

    logic             in_ready_c;
    logic             accept_c;
    logic             cnt_full_c;
    logic [CNT_W-1:0] cnt_inc_c;
    tt_t              lane_tt_c;
    logic [WIDTH-1:0] lane_x_c;
    logic [WIDTH-1:0] lane_y_c;
    logic [WIDTH-1:0] lane_res_c;

    assign in_ready_c = !out_valid_q || bus.out_ready;
    assign accept_c   = bus.in_valid && in_ready_c;
    assign cnt_full_c = (cnt_q == CNT_MAX);
    assign cnt_inc_c  = cnt_full_c ? cnt_q : cnt_q + CNT_ONE;

    // Lane operands: live cfg with (a,b) for MAP, latched table with (acc,a) mid-packet
    always_comb begin
        lane_tt_c = bus.cfg_tt;
        lane_x_c  = bus.in_a;
        lane_y_c  = bus.in_b;
        if (state_q == ST_ACC) begin
            lane_tt_c = tt_q;
            lane_x_c  = acc_q;
            lane_y_c  = bus.in_a;
        end
    end

    bool_tt_lane #(.WIDTH(WIDTH)) u_lane (
        .tt_i  (lane_tt_c),
        .x_i   (lane_x_c),
        .y_i   (lane_y_c),
        .res_o (lane_res_c)
    );

    // Next-state, accumulator and output-register load logic
    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        sat_d       = sat_q;
        tt_d        = tt_q;
        out_valid_d = out_valid_q && !bus.out_ready;
        out_data_d  = out_data_q;
        out_beats_d = out_beats_q;
        out_sat_d   = out_sat_q;

        if (accept_c) begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.cfg_fold) begin
                        tt_d  = bus.cfg_tt;
                        acc_d = bus.in_a;
                        cnt_d = CNT_ONE;
                        sat_d = 1'b0;
                        if (bus.in_last) begin
                            out_valid_d = 1'b1;
                            out_data_d  = bus.in_a;
                            out_beats_d = CNT_ONE;
                            out_sat_d   = 1'b0;
                        end else begin
                            state_d = ST_ACC;
                        end
                    end else begin
                        out_valid_d = 1'b1;
                        out_data_d  = lane_res_c;
                        out_beats_d = CNT_ONE;
                        out_sat_d   = 1'b0;
                    end
                end
                ST_ACC: begin
                    acc_d = lane_res_c;
                    cnt_d = cnt_inc_c;
                    sat_d = sat_q || cnt_full_c;
                    if (bus.in_last) begin
                        out_valid_d = 1'b1;
                        out_data_d  = lane_res_c;
                        out_beats_d = cnt_inc_c;
                        out_sat_d   = sat_q || cnt_full_c;
                        state_d     = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            acc_q       <= '0;
            cnt_q       <= '0;
            sat_q       <= 1'b0;
            tt_q        <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_beats_q <= '0;
            out_sat_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            sat_q       <= sat_d;
            tt_q        <= tt_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_beats_q <= out_beats_d;
            out_sat_q   <= out_sat_d;
        end
    end

    assign bus.in_ready  = in_ready_c;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_beats = out_beats_q;
    assign bus.out_sat   = out_sat_q;

endmodule
